reg_skid_rst_y_mode_s: RTL and testbench
========================================

// Module: reg_skid_rst_y_mode_s
//
// PURPOSE
//   Two-entry valid/ready skid buffer. It registers a data stream at full throughput.
//   It sits directly upstream of the enable-gated data register: o_valid drives that
//   register's i_en and o_data drives its i_data. o_ready is a pure flop output, so
//   backpressure from downstream is never a combinational path through this stage.
//
// PARAMETERS
//   DATA_WIDTH  32  payload width in bits
//   RST_VAL     0   reset value of o_data and of the internal skid register
//
// PORTS
//   i_clk    in   1           clock; all flops update on the rising edge
//   i_rst    in   1           synchronous reset, active-high
//   i_valid  in   1           upstream data valid
//   o_ready  out  1           stage can accept; registered
//   i_data   in   DATA_WIDTH  upstream payload
//   o_valid  out  1           downstream data valid; registered
//   i_ready  in   1           downstream can accept
//   o_data   out  DATA_WIDTH  downstream payload; registered
//
// BEHAVIOUR
//   - Transfer definitions:
//     - in_fire  = i_valid & o_ready
//     - out_fire = o_valid & i_ready
//   - Reset: i_rst high at a rising edge forces the following values, with no
//     dependence on other inputs:
//     - state = EMPTY
//     - o_valid = 0
//     - o_ready = 0
//     - o_data = RST_VAL
//     - skid = RST_VAL
//   - o_ready goes to 1 at the first edge where i_rst is low.
//   - Reset mid-operation discards both entries. No output is produced for data
//     held at reset.
//   - State machine (2-bit encoding; the remaining code is treated as EMPTY):
//     - EMPTY: o_valid=0, o_ready=1.
//       - in_fire -> BUSY; o_data <= i_data.
//     - BUSY: o_valid=1, o_ready=1.
//       - in_fire & out_fire -> BUSY; o_data <= i_data.
//       - in_fire & !out_fire -> FULL; skid <= i_data; o_data holds.
//       - !in_fire & out_fire -> EMPTY; o_data holds its last value.
//       - neither -> BUSY, no change.
//     - FULL: o_valid=1, o_ready=0. i_valid/i_data are ignored.
//       - out_fire -> BUSY; o_data <= skid.
//       - otherwise hold.
//   - Flop definitions:
//     - o_ready flop <= (next_state != FULL)
//     - o_valid flop <= (next_state != EMPTY)
//   - Latency and throughput:
//     - i_valid to o_valid: 1 cycle.
//     - Sustained throughput is 1 word/cycle while i_ready stays high.
//   - Ordering: strict FIFO; no word is duplicated or dropped.
//   - Stability: while o_valid & !i_ready, o_data and o_valid do not change.
//   - Boundary cases:
//     - A single i_ready low cycle in BUSY with upstream streaming absorbs one word
//       into skid. o_ready falls the next cycle.
//     - i_valid asserted while o_ready=0 has no effect.
//     - In FULL, out_fire and i_valid in the same cycle: only the skid word moves.
//       The upstream word is accepted next cycle once o_ready=1.
//   - Width: data paths are pass-through only, with no arithmetic.
//
// TESTING
//   1. Reset: i_rst=1 for 2 cycles, any inputs -> o_valid=0, o_ready=0,
//      o_data=32'h0. At the first edge with i_rst=0, o_ready=1.
//   2. Stream: i_ready=1; send 32'hFFFF0000, 32'hFFFF00FF, 32'hFFFFFFFF on
//      consecutive cycles -> same 3 words on o_data, each 1 cycle later.
//      o_valid high for 3 cycles; o_ready stays 1.
//   3. Stall: i_ready=0 while sending A=32'h1, B=32'h2, C=32'h3 ->
//      - A held on o_data.
//      - B accepted into skid; o_ready=0 the next cycle.
//      - C held upstream.
//      - After i_ready=1: o_data shows A, B, C in order.
//   4. FULL drain with pending input: FULL with A out and B in skid, i_valid=1 with
//      C, i_ready=1 -> o_data A then B then C. C is not lost or duplicated.
//   5. Reset mid-operation: FULL state, pulse i_rst for 1 cycle -> o_valid=0 and
//      o_data=RST_VAL the next cycle. No stale word appears afterwards.
//   6. Random valid/ready: 1000 words, 50% toggle on each side -> scoreboard
//      order/count match. o_data stable whenever o_valid & !i_ready.

Source files
------------

// File: rtl/reg_skid_rst_y_mode_s.sv
// Two-entry valid/ready skid buffer with fully registered handshake outputs.
// Feeds an enable-gated data register: o_valid acts as its enable and o_data as its payload.
module reg_skid_rst_y_mode_s #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data
);

  // Occupancy: EMPTY holds nothing, BUSY holds o_data, FULL holds o_data plus skid.
  // The unused code 2'b11 behaves as EMPTY.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] skid;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic [DATA_WIDTH-1:0] skid_nxt;
  logic                  in_fire;
  logic                  out_fire;

  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  // State and handshake flags; flags are derived from the next state so they are plain flops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= EMPTY;
      o_valid <= 1'b0;
      o_ready <= 1'b0;
    end else begin
      state   <= state_nxt;
      o_valid <= (state_nxt != EMPTY);
      o_ready <= (state_nxt != FULL);
    end
  end

  // Payload registers: output word and the single skid entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data <= RST_VAL;
      skid   <= RST_VAL;
    end else begin
      o_data <= data_nxt;
      skid   <= skid_nxt;
    end
  end

  // Next-state and next-payload selection.
  always_comb begin
    state_nxt = state;
    data_nxt  = o_data;
    skid_nxt  = skid;
    case (state)
      BUSY: begin
        if (in_fire && out_fire) begin
          data_nxt = i_data;
        end else if (in_fire) begin
          state_nxt = FULL;
          skid_nxt  = i_data;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // Upstream is stalled here; only the skid word can advance.
        if (out_fire) begin
          state_nxt = BUSY;
          data_nxt  = skid;
        end
      end
      default: begin
        if (in_fire) begin
          state_nxt = BUSY;
          data_nxt  = i_data;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_reg_skid_rst_y_mode_s.sv
// Bench for reg_skid_rst_y_mode_s: vector table, hand-written corner sequences, random traffic.
module tb_reg_skid_rst_y_mode_s;

  localparam int unsigned   DW = 32;
  localparam logic [DW-1:0] RV = '0;

  logic          clk = 1'b0;
  logic          i_rst;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] i_data;
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] o_data;

  reg_skid_rst_y_mode_s #(.DATA_WIDTH(DW), .RST_VAL(RV)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          r;
    logic          ev;
    logic          er;
    logic [DW-1:0] ed;
  } vec_t;

  vec_t          tbl [10];
  logic [DW-1:0] sb [$];
  int            total = 0;
  int            bad   = 0;
  int            cnt   = 0;
  int            rcv   = 0;
  bit            in_f;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One clock of traffic: scoreboard update at the handshake, occupancy model check after the edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r);
    logic          out_f;
    logic          hold;
    logic [DW-1:0] hd;
    i_rst   = 1'b0;
    i_valid = v;
    i_data  = d;
    i_ready = r;
    in_f  = v & o_ready;
    out_f = o_valid & r;
    hold  = o_valid & ~r;
    hd    = o_data;
    if (out_f) begin
      rcv++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stale_out: got %h want no word", o_data);
      end else begin
        chk("sb_data", o_data, sb.pop_front());
      end
    end
    if (in_f) sb.push_back(d);
    cnt = cnt + int'(in_f) - int'(out_f);
    @(posedge clk);
    #1;
    chk("model_valid", DW'(o_valid), DW'(cnt > 0));
    chk("model_ready", DW'(o_ready), DW'(cnt < 2));
    if (hold) begin
      chk("stable_data", o_data, hd);
      chk("stable_valid", DW'(o_valid), DW'(1));
    end
  endtask

  task automatic do_reset(input int n);
    i_rst = 1'b1;
    repeat (n) begin
      i_valid = 1'($urandom_range(0, 1));
      i_ready = 1'($urandom_range(0, 1));
      i_data  = $urandom;
      @(posedge clk);
      #1;
      chk("rst_valid", DW'(o_valid), DW'(0));
      chk("rst_ready", DW'(o_ready), DW'(0));
      chk("rst_data", o_data, RV);
    end
    sb.delete();
    cnt = 0;
    // Upstream offers a word while o_ready is still low: it must be ignored.
    i_rst   = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'hDEAD_BEEF;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_ready", DW'(o_ready), DW'(1));
    chk("rel_valid", DW'(o_valid), DW'(0));
    chk("rel_data", o_data, RV);
  endtask

  initial begin
    int sent;
    int cyc;
    int rcv0;
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = '0;

    // Stream of three words, then a stall that fills the skid and drains with C pending.
    tbl[0] = '{1'b1, 32'hFFFF0000, 1'b1, 1'b1, 1'b1, 32'hFFFF0000};
    tbl[1] = '{1'b1, 32'hFFFF00FF, 1'b1, 1'b1, 1'b1, 32'hFFFF00FF};
    tbl[2] = '{1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF};
    tbl[3] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'hFFFFFFFF};
    tbl[4] = '{1'b1, 32'h1,        1'b0, 1'b1, 1'b1, 32'h1};
    tbl[5] = '{1'b1, 32'h2,        1'b0, 1'b1, 1'b0, 32'h1};
    tbl[6] = '{1'b1, 32'h3,        1'b0, 1'b1, 1'b0, 32'h1};
    tbl[7] = '{1'b1, 32'h3,        1'b1, 1'b1, 1'b1, 32'h2};
    tbl[8] = '{1'b1, 32'h3,        1'b1, 1'b1, 1'b1, 32'h3};
    tbl[9] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h3};

    do_reset(2);

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_valid", i), DW'(o_valid), DW'(tbl[i].ev));
      chk($sformatf("tbl%0d_ready", i), DW'(o_ready), DW'(tbl[i].er));
      chk($sformatf("tbl%0d_data", i), o_data, tbl[i].ed);
    end

    // Reset while FULL: both entries are discarded and nothing stale emerges.
    cycle(1'b1, 32'hA0A0_0001, 1'b0);
    cycle(1'b1, 32'hB0B0_0002, 1'b0);
    chk("full_ready", DW'(o_ready), DW'(0));
    i_rst   = 1'b1;
    i_valid = 1'b1;
    i_data  = 32'hC0C0_0003;
    i_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_valid", DW'(o_valid), DW'(0));
    chk("midrst_ready", DW'(o_ready), DW'(0));
    chk("midrst_data", o_data, RV);
    sb.delete();
    cnt = 0;
    repeat (3) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 32'h0D0D_0004, 1'b1);
    chk("post_rst_data", o_data, 32'h0D0D_0004);
    cycle(1'b0, '0, 1'b1);

    // Random valid/ready traffic.
    sent = 0;
    cyc  = 0;
    rcv0 = rcv;
    while (sent < 1000 && cyc < 20000) begin
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      if (in_f) sent++;
      cyc++;
    end
    chk("rand_sent", DW'(sent), DW'(1000));
    cyc = 0;
    while (sb.size() > 0 && cyc < 10) begin
      cycle(1'b0, '0, 1'b1);
      cyc++;
    end
    chk("rand_drain", DW'(sb.size()), DW'(0));
    chk("rand_rcv", DW'(rcv - rcv0), DW'(1000));
    chk("rand_idle_valid", DW'(o_valid), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
